sample_iterator: RTL and testbench

Walks the snapped bounding box of one accepted triangle and emits one sample location per cycle, in raster order, at the current MSAA step. Its outputs drive the sample test stage, which expects a triangle, a color, a sample position and a valid bit. Upstream (bounding box stage) is throttled with a registered halt signal. One triangle is in flight at a time.

---
 rtl/raster_pkg.sv | 34 +++
 rtl/sample_axis_step.sv | 21 ++
 rtl/sample_iterator.sv | 125 ++++++++++++
 tb/tb_sample_iterator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared raster definitions: default widths, iterator states, MSAA encodings.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package raster_pkg;

    localparam int SIGFIG_DEF = 24;
    localparam int RADIX_DEF  = 10;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_t;

    // One-hot MSAA mode encodings on subSample_RnnnnU
    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Right-shift applied to one pixel to get the sample step; unknown codes fall back to 1x
    function automatic logic [1:0] step_shift(input logic [3:0] ss);
        logic [1:0] k;
        k = 2'd0;
        case (ss)
            SS_1X:   k = 2'd0;
            SS_4X:   k = 2'd1;
            SS_16X:  k = 2'd2;
            SS_64X:  k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sample_axis_step.sv
// One axis of the sample walk: next = cur + step, and whether that overshoots the limit.
// Latency: combinational.
// Backpressure: none; the caller decides whether to take next or wrap.
module sample_axis_step #(
    parameter int SIGFIG = 24
) (
    input  logic signed [SIGFIG-1:0] cur,
    input  logic        [SIGFIG-1:0] step,
    input  logic signed [SIGFIG-1:0] limit,
    output logic signed [SIGFIG-1:0] nxt,
    output logic                     wrap
);

    // One extra bit so a walk near the top of the signed range cannot wrap and look in-box
    logic signed [SIGFIG:0] sum;

    assign sum  = $signed({cur[SIGFIG-1], cur}) + $signed({1'b0, step});
    assign wrap = sum > $signed({limit[SIGFIG-1], limit});
    assign nxt  = sum[SIGFIG-1:0];

endmodule

// File: rtl/sample_iterator.sv
// Walks one triangle's bounding box in raster order, one sample per cycle at the latched MSAA step.
// Latency: first sample one cycle after accept; box of C x R points is valid for C*R cycles.
// Backpressure: halt (== valid sample) holds upstream; validTri is ignored while halted.
module sample_iterator
    import raster_pkg::*;
#(
    parameter int SIGFIG = SIGFIG_DEF,
    parameter int RADIX  = RADIX_DEF,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R14S,
    input  logic                                          validTri_R14H,
    input  logic        [3:0]                             subSample_RnnnnU,
    output logic                                          halt_RnnnnH,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R16U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R16S,
    output logic                                          validSamp_R16H
);

    state_t state, next_state;
    logic   load;

    logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
    logic signed [SIGFIG-1:0] cur_x, cur_y;
    logic        [SIGFIG-1:0] step;

    logic signed [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y;
    logic                     degenerate;
    logic        [SIGFIG-1:0] step_in;

    logic signed [SIGFIG-1:0] nxt_x, nxt_y;
    logic                     wrap_x, wrap_y;

    assign in_ll_x    = box_R14S[0][0];
    assign in_ll_y    = box_R14S[0][1];
    assign in_ur_x    = box_R14S[1][0];
    assign in_ur_y    = box_R14S[1][1];
    assign degenerate = (in_ll_x > in_ur_x) || (in_ll_y > in_ur_y);
    assign step_in    = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(step_shift(subSample_RnnnnU)));

    sample_axis_step #(.SIGFIG(SIGFIG)) u_step_x (
        .cur   (cur_x),
        .step  (step),
        .limit (ur_x),
        .nxt   (nxt_x),
        .wrap  (wrap_x)
    );

    sample_axis_step #(.SIGFIG(SIGFIG)) u_step_y (
        .cur   (cur_y),
        .step  (step),
        .limit (ur_y),
        .nxt   (nxt_y),
        .wrap  (wrap_y)
    );

    // State register; reset drops any partial box
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_STATE;
        else      state <= next_state;
    end

    // Accept non-degenerate triangles in WAIT; leave TEST once both axes overshoot
    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            WAIT_STATE: begin
                if (validTri_R14H && !degenerate) begin
                    load       = 1'b1;
                    next_state = TEST_STATE;
                end
            end
            TEST_STATE: begin
                if (wrap_x && wrap_y) next_state = WAIT_STATE;
            end
            default: next_state = WAIT_STATE;
        endcase
    end

    // Latch triangle, box and step at accept; advance the raster walk while testing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_R16S   <= '0;
            color_R16U <= '0;
            ll_x       <= '0;
            ll_y       <= '0;
            ur_x       <= '0;
            ur_y       <= '0;
            step       <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
        end else if (load) begin
            tri_R16S   <= tri_R14S;
            color_R16U <= color_R14U;
            ll_x       <= in_ll_x;
            ll_y       <= in_ll_y;
            ur_x       <= in_ur_x;
            ur_y       <= in_ur_y;
            step       <= step_in;
            cur_x      <= in_ll_x;
            cur_y      <= in_ll_y;
        end else if (state == TEST_STATE) begin
            if (!wrap_x) begin
                cur_x <= nxt_x;
            end else begin
                cur_x <= ll_x;
                if (!wrap_y) cur_y <= nxt_y;
            end
        end
    end

    assign sample_R16S[0] = cur_x;
    assign sample_R16S[1] = cur_y;
    assign validSamp_R16H = (state == TEST_STATE);
    assign halt_RnnnnH    = (state == TEST_STATE);

endmodule

// File: tb/tb_sample_iterator.sv
module tb_sample_iterator;

    localparam int SF = 24;

    typedef logic [2:0][2:0][SF-1:0] tri_t;
    typedef logic [2:0][SF-1:0]      col_t;
    typedef struct {
        logic [SF-1:0] x;
        logic [SF-1:0] y;
        tri_t          t;
        col_t          c;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    tri_t                   tri_in = '0;
    col_t                   col_in = '0;
    logic [1:0][1:0][SF-1:0] box_in = '0;
    logic                   vtri = 1'b0;
    logic [3:0]             ss = 4'b1000;
    logic                   halt;
    tri_t                   tri_out;
    col_t                   col_out;
    logic [1:0][SF-1:0]     samp;
    logic                   vsamp;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R14S         (tri_in),
        .color_R14U       (col_in),
        .box_R14S         (box_in),
        .validTri_R14H    (vtri),
        .subSample_RnnnnU (ss),
        .halt_RnnnnH      (halt),
        .tri_R16S         (tri_out),
        .color_R16U       (col_out),
        .sample_R16S      (samp),
        .validSamp_R16H   (vsamp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid sample must match the next expected grid point of the current triangle
    always @(negedge clk) begin
        if (rst) begin
            chk("halt_eq_valid", 128'(halt), 128'(vsamp));
            if (vsamp) begin
                if (sb.size() == 0) begin
                    chk("unexpected_sample", 128'(samp), 128'hdead);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sample_x", 128'(samp[0]), 128'(e.x));
                    chk("sample_y", 128'(samp[1]), 128'(e.y));
                    chk("tri", 128'(tri_out), 128'(e.t));
                    chk("color", 128'(col_out), 128'(e.c));
                end
            end
        end
    end

    function automatic int step_of(input logic [3:0] m);
        case (m)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Reference: every grid point from ll stepping by step, up to and including ur, rows bottom-up
    function automatic int model_push(input tri_t t, input col_t c, input int llx, input int lly,
                                      input int urx, input int ury, input int st);
        int n;
        exp_t e;
        n = 0;
        if (llx > urx || lly > ury) return 0;
        for (int y = lly; y <= ury; y += st) begin
            for (int x = llx; x <= urx; x += st) begin
                e.x = x[SF-1:0];
                e.y = y[SF-1:0];
                e.t = t;
                e.c = c;
                sb.push_back(e);
                n++;
            end
        end
        return n;
    endfunction

    // Present a triangle and return once it has been taken (or dropped) at an edge with halt low
    task automatic send(input tri_t t, input col_t c, input int llx, input int lly,
                        input int urx, input int ury, input logic [3:0] mode, output int n);
        int cyc;
        @(negedge clk);
        tri_in = t;
        col_in = c;
        box_in[0][0] = llx[SF-1:0];
        box_in[0][1] = lly[SF-1:0];
        box_in[1][0] = urx[SF-1:0];
        box_in[1][1] = ury[SF-1:0];
        ss   = mode;
        vtri = 1'b1;
        cyc  = 0;
        while (halt && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (halt) chk("accept_timeout", 128'(halt), 128'(0));
        n = model_push(t, c, llx, lly, urx, ury, step_of(ss));
        @(posedge clk);
        #1;
    endtask

    // After an accept edge: count valid cycles until halt is seen low; expect n valid then one idle
    task automatic wait_idle(input string name, input int n);
        int cyc, cnt;
        cyc = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (vsamp) cnt++;
        end while (halt && cyc < 300);
        chk({name, "_valid_cycles"}, 128'(cnt), 128'(n));
        chk({name, "_halt_fall_cycle"}, 128'(cyc), 128'(n + 1));
        chk({name, "_drained"}, 128'(sb.size()), 128'(0));
    endtask

    function automatic tri_t rnd_tri();
        tri_t t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) t[i][j] = SF'($urandom);
        return t;
    endfunction

    function automatic col_t rnd_col();
        col_t c;
        for (int i = 0; i < 3; i++) c[i] = SF'($urandom);
        return c;
    endfunction

    initial begin
        int n, n2, st, llx, lly, urx, ury;
        logic [3:0] modes [4];
        modes[0] = 4'b1000; modes[1] = 4'b0100; modes[2] = 4'b0010; modes[3] = 4'b0001;

        #2;
        chk("rst_valid", 128'(vsamp), 128'(0));
        chk("rst_halt", 128'(halt), 128'(0));
        chk("rst_sample", 128'(samp), 128'(0));
        chk("rst_tri", 128'(tri_out), 128'(0));
        chk("rst_color", 128'(col_out), 128'(0));
        #20;
        rst = 1'b1;

        // 1x, 3 x 2 box
        send(rnd_tri(), rnd_col(), 0, 0, 2048, 1024, 4'b1000, n);
        vtri = 1'b0;
        chk("s1_count", 128'(n), 128'(6));
        wait_idle("s1", n);

        // 4x, 2 x 2 box
        send(rnd_tri(), rnd_col(), 512, 512, 1024, 1024, 4'b0100, n);
        vtri = 1'b0;
        wait_idle("s2", n);

        // single point
        send(rnd_tri(), rnd_col(), 3072, 2048, 3072, 2048, 4'b1000, n);
        vtri = 1'b0;
        wait_idle("s3", n);

        // degenerate box dropped, next triangle accepted the following cycle
        send(rnd_tri(), rnd_col(), 2048, 0, 1024, 0, 4'b1000, n);
        chk("s4_dropped", 128'(n), 128'(0));
        chk("s4_no_halt", 128'(halt), 128'(0));
        send(rnd_tri(), rnd_col(), 0, 0, 1024, 0, 4'b1000, n);
        vtri = 1'b0;
        @(negedge clk);
        chk("s4_next_accept_valid", 128'(vsamp), 128'(1));
        chk("s4_next_accept_x", 128'(samp[0]), 128'(0));
        @(negedge clk);
        @(negedge clk);
        chk("s4_idle", 128'(halt), 128'(0));
        chk("s4_drained", 128'(sb.size()), 128'(0));

        // validTri held with a new triangle and 16x mode while the first box is walked
        send(rnd_tri(), rnd_col(), 0, 0, 2048, 1024, 4'b1000, n);
        send(rnd_tri(), rnd_col(), 0, 0, 512, 256, 4'b0010, n2);
        vtri = 1'b0;
        chk("s5_second_count", 128'(n2), 128'(6));
        wait_idle("s5", n2);

        // reset pulsed during the third sample
        send(rnd_tri(), rnd_col(), 0, 0, 2048, 1024, 4'b1000, n);
        vtri = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_valid_clear", 128'(vsamp), 128'(0));
        chk("s6_halt_clear", 128'(halt), 128'(0));
        chk("s6_sample_clear", 128'(samp), 128'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("s6_no_samples", 128'(vsamp), 128'(0));
        end

        // randomized boxes across modes, including non-aligned and degenerate corners
        for (int k = 0; k < 30; k++) begin
            logic [3:0] m;
            m   = modes[$urandom_range(0, 3)];
            st  = step_of(m);
            llx = (int'($urandom_range(0, 40)) - 20) * st;
            lly = (int'($urandom_range(0, 40)) - 20) * st;
            urx = llx + int'($urandom_range(0, 3)) * st;
            ury = lly + int'($urandom_range(0, 3)) * st;
            if ($urandom_range(0, 3) == 0) urx += int'($urandom_range(0, st - 1));
            if ($urandom_range(0, 3) == 0) ury += int'($urandom_range(0, st - 1));
            if ($urandom_range(0, 9) == 0) urx = llx - st;
            send(rnd_tri(), rnd_col(), llx, lly, urx, ury, m, n);
            vtri = 1'b0;
            ss   = modes[$urandom_range(0, 3)];
            wait_idle("rand", n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
